// File: rtl/echo_mixer.sv
// echo_mixer: three-tap weighted mixer for the echo stage with a PWM DAC output.
//
// A rising edge of sample_stb (while enable is high) captures the three
// offset-binary taps and their gains, runs a three-step multiply-accumulate,
// then shifts, saturates and re-offsets the sum onto mix_out. It takes four
// clocks from capture to output.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   enable       low blocks new sample strobes (an in-flight sample completes)
//   sample_stb   new-sample level; a rising edge starts a computation
//   realt        tap 0, unsigned offset-binary (0x80 = silence)
//   delay1       tap 1, unsigned offset-binary
//   delay2       tap 2, unsigned offset-binary
//   gain0..2     unsigned tap gains (128 = unity at GAIN_SHIFT = 7)
//   overrun_clr  clears the sticky overrun flag
//   mix_out      mixed sample, offset-binary, held between updates
//   mix_valid    one-cycle pulse when mix_out updates
//   busy         high while a sample is being computed
//   overrun      sticky: a strobe edge arrived while busy and was dropped
//   pwm_out      registered 8-bit PWM of mix_out
module echo_mixer #(
  parameter int unsigned GAIN_SHIFT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_stb,
  input  logic [7:0] realt,
  input  logic [7:0] delay1,
  input  logic [7:0] delay2,
  input  logic [7:0] gain0,
  input  logic [7:0] gain1,
  input  logic [7:0] gain2,
  input  logic       overrun_clr,
  output logic [7:0] mix_out,
  output logic       mix_valid,
  output logic       busy,
  output logic       overrun,
  output logic       pwm_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic               stb_q;
  logic signed [7:0]  tap0_q, tap0_d, tap1_q, tap1_d, tap2_q, tap2_d;
  logic [7:0]         gain0_q, gain0_d, gain1_q, gain1_d, gain2_q, gain2_d;
  logic signed [17:0] acc_q, acc_d;
  logic [7:0]         mix_q, mix_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         cnt_q, duty_q;
  logic               pwm_q;

  logic               edge_w;
  logic signed [7:0]  tap_sel;
  logic [7:0]         gain_sel;
  logic signed [16:0] prod;
  logic signed [17:0] acc_shr;
  logic [7:0]         sat;

  assign edge_w = sample_stb & ~stb_q & enable;

  // Operand select for the single shared multiplier.
  always_comb begin
    tap_sel  = tap0_q;
    gain_sel = gain0_q;
    case (state_q)
      S_MAC1: begin
        tap_sel  = tap1_q;
        gain_sel = gain1_q;
      end
      S_MAC2: begin
        tap_sel  = tap2_q;
        gain_sel = gain2_q;
      end
      default: ;
    endcase
  end

  // Gain is unsigned: zero-extend before going signed so 255 stays positive.
  assign prod = $signed(17'(tap_sel)) * $signed(17'({1'b0, gain_sel}));

  // Arithmetic shift floors toward -inf, then clamp to the 8-bit signed range.
  assign acc_shr = acc_q >>> GAIN_SHIFT;

  always_comb begin
    if (acc_shr > 18'sd127)
      sat = 8'h7F;
    else if (acc_shr < -18'sd128)
      sat = 8'h80;
    else
      sat = acc_shr[7:0];
  end

  always_comb begin
    state_d = state_q;
    tap0_d  = tap0_q;
    tap1_d  = tap1_q;
    tap2_d  = tap2_q;
    gain0_d = gain0_q;
    gain1_d = gain1_q;
    gain2_d = gain2_q;
    acc_d   = acc_q;
    mix_d   = mix_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (edge_w) begin
          state_d = S_MAC0;
          tap0_d  = {~realt[7], realt[6:0]};
          tap1_d  = {~delay1[7], delay1[6:0]};
          tap2_d  = {~delay2[7], delay2[6:0]};
          gain0_d = gain0;
          gain1_d = gain1;
          gain2_d = gain2;
          acc_d   = '0;
        end
      end
      S_MAC0: begin
        acc_d   = acc_q + 18'(prod);
        state_d = S_MAC1;
      end
      S_MAC1: begin
        acc_d   = acc_q + 18'(prod);
        state_d = S_MAC2;
      end
      S_MAC2: begin
        acc_d   = acc_q + 18'(prod);
        state_d = S_OUT;
      end
      S_OUT: begin
        mix_d   = {~sat[7], sat[6:0]};
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set has priority over clear when both happen in the same cycle.
    ovr_d = ovr_q;
    if (overrun_clr)
      ovr_d = 1'b0;
    if (edge_w && (state_q != S_IDLE))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stb_q   <= 1'b0;
      tap0_q  <= '0;
      tap1_q  <= '0;
      tap2_q  <= '0;
      gain0_q <= '0;
      gain1_q <= '0;
      gain2_q <= '0;
      acc_q   <= '0;
      mix_q   <= 8'h80;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      duty_q  <= 8'h80;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= sample_stb;
      tap0_q  <= tap0_d;
      tap1_q  <= tap1_d;
      tap2_q  <= tap2_d;
      gain0_q <= gain0_d;
      gain1_q <= gain1_d;
      gain2_q <= gain2_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_q + 8'd1;
      // Duty only reloads at the period boundary so a period is never torn.
      if (cnt_q == 8'hFF)
        duty_q <= mix_q;
      pwm_q   <= (cnt_q < duty_q);
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = ovr_q;
  assign pwm_out   = pwm_q;

endmodule
